// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter in front of a saturating two's complement
// adder with a PIPES-deep output pipeline. The whole pipeline advances or
// stalls as one unit, driven by the downstream valid/ready handshake.
module adder_arbiter #(
  parameter int DATAW = 32,
  parameter int NREQ  = 4,
  parameter int PIPES = 2,
  localparam int IDW  = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NREQ-1:0][DATAW-1:0] req_dataa_i,
  input  logic [NREQ-1:0][DATAW-1:0] req_datab_i,
  input  logic [NREQ-1:0]            req_valid_i,
  output logic [NREQ-1:0]            req_ready_o,
  output logic [DATAW-1:0]           sum_o,
  output logic [IDW-1:0]             id_o,
  output logic                       ovf_o,
  output logic                       valid_o,
  input  logic                       ready_i
);

  // Returns {ovf, sum}: the sum is clamped to the most positive or most
  // negative representable value when the exact result does not fit.
  function automatic logic [DATAW:0] sat_add(input logic signed [DATAW-1:0] a,
                                             input logic signed [DATAW-1:0] b);
    logic signed [DATAW:0] full;
    logic [DATAW:0]        res;
    full = $signed({a[DATAW-1], a}) + $signed({b[DATAW-1], b});
    if (full[DATAW] != full[DATAW-1]) begin
      if (full[DATAW]) res = {1'b1, 1'b1, {(DATAW-1){1'b0}}};
      else             res = {1'b1, 1'b0, {(DATAW-1){1'b1}}};
    end else begin
      res = {1'b0, full[DATAW-1:0]};
    end
    return res;
  endfunction

  logic [IDW-1:0]   ptr_q, ptr_d;
  logic             vld_q [PIPES];
  logic             vld_d [PIPES];
  logic [DATAW-1:0] sum_q [PIPES];
  logic [DATAW-1:0] sum_d [PIPES];
  logic [IDW-1:0]   id_q  [PIPES];
  logic [IDW-1:0]   id_d  [PIPES];
  logic             ovf_q [PIPES];
  logic             ovf_d [PIPES];

  logic             advance;
  logic             found;
  logic             hs;
  logic [IDW-1:0]   gnt_idx;
  logic [NREQ-1:0]  grant;
  logic [DATAW:0]   add_res;

  // A global stall: every stage moves only when the last stage can drain.
  assign advance = !vld_q[PIPES-1] || ready_i;
  assign hs      = found && advance;

  // Round-robin scan starting at ptr; grant is derived only from valids.
  always_comb begin : arb_comb
    int j;
    int nxt;
    j       = 0;
    nxt     = 0;
    found   = 1'b0;
    gnt_idx = '0;
    grant   = '0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(ptr_q) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req_valid_i[j]) begin
        found   = 1'b1;
        gnt_idx = IDW'(j);
      end
    end
    if (found) grant[gnt_idx] = 1'b1;
    nxt = int'(gnt_idx) + 1;
    if (nxt >= NREQ) nxt = 0;
    ptr_d = hs ? IDW'(nxt) : ptr_q;
  end

  assign req_ready_o = grant & {NREQ{advance}};
  assign add_res     = sat_add(req_dataa_i[gnt_idx], req_datab_i[gnt_idx]);

  // Next-state of the result pipeline: load stage 0 from the adder, shift the rest.
  always_comb begin
    for (int s = 0; s < PIPES; s++) begin
      vld_d[s] = vld_q[s];
      sum_d[s] = sum_q[s];
      id_d[s]  = id_q[s];
      ovf_d[s] = ovf_q[s];
    end
    if (advance) begin
      vld_d[0] = hs;
      sum_d[0] = hs ? add_res[DATAW-1:0] : '0;
      id_d[0]  = hs ? gnt_idx : '0;
      ovf_d[0] = hs ? add_res[DATAW] : 1'b0;
      for (int s = 1; s < PIPES; s++) begin
        vld_d[s] = vld_q[s-1];
        sum_d[s] = sum_q[s-1];
        id_d[s]  = id_q[s-1];
        ovf_d[s] = ovf_q[s-1];
      end
    end
  end

  // State registers; reset flushes every in-flight result and restarts the pointer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
      for (int s = 0; s < PIPES; s++) begin
        vld_q[s] <= 1'b0;
        sum_q[s] <= '0;
        id_q[s]  <= '0;
        ovf_q[s] <= 1'b0;
      end
    end else begin
      ptr_q <= ptr_d;
      for (int s = 0; s < PIPES; s++) begin
        vld_q[s] <= vld_d[s];
        sum_q[s] <= sum_d[s];
        id_q[s]  <= id_d[s];
        ovf_q[s] <= ovf_d[s];
      end
    end
  end

  assign valid_o = vld_q[PIPES-1];
  assign sum_o   = sum_q[PIPES-1];
  assign id_o    = id_q[PIPES-1];
  assign ovf_o   = ovf_q[PIPES-1];

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter (DATAW=8, NREQ=4, PIPES=2): the driver
// pushes hand-computed results as requests are accepted, a monitor pops and
// compares them whenever a result is consumed downstream.
module tb_adder_arbiter;

  logic             clk;
  logic             rst_i;
  logic [3:0][7:0]  dataa;
  logic [3:0][7:0]  datab;
  logic [3:0]       req_valid_i;
  logic [3:0]       req_ready_o;
  logic [7:0]       sum_o;
  logic [1:0]       id_o;
  logic             ovf_o;
  logic             valid_o;
  logic             ready_i;

  typedef struct packed {
    logic [7:0] sum;
    logic [1:0] id;
    logic       ovf;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  logic       hold_v = 1'b0;
  logic [7:0] hold_sum;
  logic [1:0] hold_id;
  logic       hold_ovf;

  // Per-requester expected results for the operands used in the streaming phase.
  logic [7:0] e_sum [4] = '{8'h7F, 8'h80, 8'hFE, 8'h7F};
  logic       e_ovf [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  adder_arbiter #(.DATAW(8), .NREQ(4), .PIPES(2)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_dataa_i (dataa),
    .req_datab_i (datab),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .sum_o       (sum_o),
    .id_o        (id_o),
    .ovf_o       (ovf_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] s, input logic [1:0] i, input logic o);
    exp_t e;
    e.sum = s;
    e.id  = i;
    e.ovf = o;
    sb_q.push_back(e);
  endtask

  // Monitor: compare consumed results in order and check outputs hold during a stall.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_i) begin
      if (hold_v && valid_o)
        check("stall_hold", {sum_o, id_o, ovf_o}, {hold_sum, hold_id, hold_ovf});
      if (valid_o && ready_i) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got id=%0d sum=%0h, required no result", id_o, sum_o);
        end else begin
          e = sb_q.pop_front();
          check("res_sum", sum_o, e.sum);
          check("res_id", id_o, e.id);
          check("res_ovf", ovf_o, e.ovf);
        end
      end
      hold_v   = valid_o && !ready_i;
      hold_sum = sum_o;
      hold_id  = id_o;
      hold_ovf = ovf_o;
    end else begin
      hold_v = 1'b0;
    end
  end

  initial begin
    logic [3:0] g;
    rst_i = 1'b1; ready_i = 1'b0; req_valid_i = '0; dataa = '0; datab = '0;
    tick; tick;
    @(negedge clk);
    check("rst_valid", valid_o, 0);
    check("rst_sum", sum_o, 0);
    check("rst_id", id_o, 0);
    check("rst_ovf", ovf_o, 0);
    tick; rst_i = 1'b0;
    @(negedge clk);
    check("post_rst_valid", valid_o, 0);

    // Positive overflow on req0 and first-result latency
    tick; ready_i = 1'b1; dataa[0] = 8'd100; datab[0] = 8'd100; req_valid_i = 4'b0001;
    @(negedge clk);
    check("grant_b", req_ready_o, 4'b0001);
    push(8'h7F, 2'd0, 1'b1);
    tick; req_valid_i = '0;
    @(negedge clk);
    check("latency_c1", valid_o, 0);
    tick;
    @(negedge clk);
    check("latency_c2", valid_o, 1);

    // Negative overflow and a plain negative sum
    tick;
    dataa[1] = 8'h9C; datab[1] = 8'h9C;
    dataa[2] = 8'hFB; datab[2] = 8'h03;
    req_valid_i = 4'b0110;
    @(negedge clk);
    check("grant_c1", req_ready_o, 4'b0010);
    push(8'h80, 2'd1, 1'b1);
    tick; req_valid_i = 4'b0100;
    @(negedge clk);
    check("grant_c2", req_ready_o, 4'b0100);
    push(8'hFE, 2'd2, 1'b0);
    tick; req_valid_i = '0;
    repeat (4) tick;

    // Two results in flight, then a one-cycle reset discards them
    ready_i = 1'b0; req_valid_i = 4'b1111;
    @(negedge clk);
    check("grant_d1", req_ready_o, 4'b1000);
    tick;
    @(negedge clk);
    check("grant_d2", req_ready_o, 4'b0001);
    tick; rst_i = 1'b1; req_valid_i = '0;
    @(negedge clk);
    check("inflight_valid", valid_o, 1);
    tick; rst_i = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", valid_o, 0);
    check("mid_rst_sum", sum_o, 0);
    check("mid_rst_id", id_o, 0);
    check("mid_rst_ovf", ovf_o, 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      @(negedge clk);
      check("no_reappear", valid_o, 0);
    end

    // All requesters valid: rotation from ptr 0, one result per cycle
    tick; ready_i = 1'b1;
    dataa[0] = 8'd100; datab[0] = 8'd27;
    dataa[1] = 8'h9C;  datab[1] = 8'h9C;
    dataa[2] = 8'hFB;  datab[2] = 8'h03;
    dataa[3] = 8'h7F;  datab[3] = 8'h01;
    req_valid_i = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      g = 4'b0001 << (i % 4);
      check("grant_rr", req_ready_o, g);
      push(e_sum[i%4], 2'(i % 4), e_ovf[i%4]);
      if (i >= 2) check("valid_stream", valid_o, 1);
      tick;
    end

    // Downstream stall with a full pipeline
    ready_i = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("grant_stall", req_ready_o, 4'b0000);
      tick;
    end
    ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      g = 4'b0001 << k;
      check("grant_resume", req_ready_o, g);
      push(e_sum[k], 2'(k), e_ovf[k]);
      tick;
    end
    req_valid_i = '0;
    repeat (4) tick;

    // Pointer follows the last grant: req2 alone, then req1 and req3
    req_valid_i = 4'b0100;
    @(negedge clk);
    check("grant_g1", req_ready_o, 4'b0100);
    push(e_sum[2], 2'd2, e_ovf[2]);
    tick; req_valid_i = 4'b1010;
    @(negedge clk);
    check("grant_g2", req_ready_o, 4'b1000);
    push(e_sum[3], 2'd3, e_ovf[3]);
    tick;
    @(negedge clk);
    check("grant_g3", req_ready_o, 4'b0010);
    push(e_sum[1], 2'd1, e_ovf[1]);
    tick; req_valid_i = '0;
    repeat (6) tick;

    @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
